// File: rtl/mem_pkg.sv
// Shared definitions for the load/store memory stage: op field layout, access sizes,
// FSM states and the store lane-replication / alignment helpers.
package mem_pkg;

  localparam int unsigned OP_W        = 4;
  localparam int unsigned DEST_W      = 5;
  localparam int unsigned SIZE_W      = 2;
  localparam int unsigned ADDR32_W    = 32;
  localparam int unsigned OFFSET_W    = 16;
  localparam int unsigned OP_STORE    = 3;
  localparam int unsigned OP_UNSIGNED = 2;

  localparam logic [SIZE_W-1:0] SZ_BYTE    = 2'b00;
  localparam logic [SIZE_W-1:0] SZ_HALF    = 2'b01;
  localparam logic [SIZE_W-1:0] SZ_WORD    = 2'b10;
  localparam logic [SIZE_W-1:0] SZ_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } mem_state_e;

  // Copy the right-aligned store data into every lane the access size covers.
  function automatic logic [31:0] replicate_store(input logic [31:0] wdata,
                                                  input logic [SIZE_W-1:0] size);
    logic [31:0] r;
    unique case (size)
      SZ_BYTE: r = {4{wdata[7:0]}};
      SZ_HALF: r = {2{wdata[15:0]}};
      default: r = wdata;
    endcase
    return r;
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [1:0] align_mask(input logic [SIZE_W-1:0] size);
    logic [1:0] m;
    unique case (size)
      SZ_HALF: m = 2'b01;
      SZ_WORD: m = 2'b11;
      default: m = 2'b00;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_stage.sv
// Load/store memory stage in front of dataRAM_r0: stores complete in one cycle, loads
// return through a registered response. MEM_STAGE_ALIGN_CHECK_EN traps misaligned accesses.
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned BIT_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OP_W-1:0]       in_op,
  input  logic [ADDR32_W-1:0]   in_base,
  input  logic [OFFSET_W-1:0]   in_offset,
  input  logic [BIT_WIDTH-1:0]  in_wdata,
  input  logic [DEST_W-1:0]     in_dest,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [BIT_WIDTH-1:0]  ram_data,
  output logic                  ram_wren,
  output logic                  ram_isSigned,
  output logic [SIZE_W-1:0]     ram_dataSize,
  input  logic [BIT_WIDTH-1:0]  ram_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIT_WIDTH-1:0]  out_data,
  output logic [DEST_W-1:0]     out_dest,
  output logic                  exc_valid,
  output logic [ADDR32_W-1:0]   exc_addr
);

  mem_state_e state_q, state_d;

  logic [ADDR32_W-1:0]   ea_c;
  logic [ADDR_WIDTH-1:0] addr_raw_c;
  logic [ADDR_WIDTH-1:0] addr_aligned_c;
  logic [SIZE_W-1:0]     size_c;
  logic                  accept_c;
  logic                  fault_c;

  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic [SIZE_W-1:0]     req_size_q;
  logic                  req_unsigned_q;
  logic [DEST_W-1:0]     req_dest_q;

  logic [BIT_WIDTH-1:0]  out_data_q;
  logic [DEST_W-1:0]     out_dest_q;
  logic                  exc_valid_q;
  logic [ADDR32_W-1:0]   exc_addr_q;

  assign size_c     = in_op[SIZE_W-1:0];
  assign ea_c       = in_base + {{(ADDR32_W-OFFSET_W){in_offset[OFFSET_W-1]}}, in_offset};
  assign addr_raw_c = ADDR_WIDTH'(ea_c);
  assign in_ready   = (state_q == IDLE);
  assign accept_c   = in_valid && in_ready;

`ifdef MEM_STAGE_ALIGN_CHECK_EN
  assign addr_aligned_c = addr_raw_c;
  assign fault_c        = (size_c == SZ_ILLEGAL) || ((addr_raw_c[1:0] & align_mask(size_c)) != 2'b00);
`else
  // Misaligned accesses are silently rounded down to the natural boundary.
  assign addr_aligned_c = addr_raw_c & ~ADDR_WIDTH'(align_mask(size_c));
  assign fault_c        = (size_c == SZ_ILLEGAL);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state plus RAM controls: live request in IDLE, latched load otherwise.
  always_comb begin
    state_d      = state_q;
    ram_addr     = '0;
    ram_data     = '0;
    ram_wren     = 1'b0;
    ram_isSigned = 1'b0;
    ram_dataSize = SZ_BYTE;
    unique case (state_q)
      IDLE: begin
        ram_addr     = addr_aligned_c;
        ram_data     = BIT_WIDTH'(replicate_store(32'(in_wdata), size_c));
        ram_isSigned = ~in_op[OP_UNSIGNED];
        ram_dataSize = size_c;
        if (accept_c && !fault_c) begin
          if (in_op[OP_STORE]) ram_wren = rst_n;
          else                 state_d  = READ;
        end
      end
      READ: begin
        ram_addr     = req_addr_q;
        ram_isSigned = ~req_unsigned_q;
        ram_dataSize = req_size_q;
        state_d      = RESP;
      end
      RESP: begin
        ram_addr     = req_addr_q;
        ram_isSigned = ~req_unsigned_q;
        ram_dataSize = req_size_q;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_addr_q     <= '0;
      req_size_q     <= '0;
      req_unsigned_q <= 1'b0;
      req_dest_q     <= '0;
      out_data_q     <= '0;
      out_dest_q     <= '0;
      exc_valid_q    <= 1'b0;
      exc_addr_q     <= '0;
    end else begin
      exc_valid_q <= accept_c && fault_c;
      if (accept_c && fault_c) exc_addr_q <= ea_c;
      if (accept_c && !fault_c && !in_op[OP_STORE]) begin
        req_addr_q     <= addr_aligned_c;
        req_size_q     <= size_c;
        req_unsigned_q <= in_op[OP_UNSIGNED];
        req_dest_q     <= in_dest;
      end
      if (state_q == READ) begin
        out_data_q <= ram_q;
        out_dest_q <= req_dest_q;
      end
    end
  end

  assign out_valid = (state_q == RESP);
  assign out_data  = out_data_q;
  assign out_dest  = out_dest_q;
  assign exc_valid = exc_valid_q;
  assign exc_addr  = exc_addr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a byte-addressed RAM model that sign/zero-extends reads.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_base;
  logic [15:0] in_offset;
  logic [31:0] in_wdata;
  logic [4:0]  in_dest;
  logic [7:0]  ram_addr;
  logic [31:0] ram_data;
  logic        ram_wren;
  logic        ram_isSigned;
  logic [1:0]  ram_dataSize;
  logic [31:0] ram_q;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_dest;
  logic        exc_valid;
  logic [31:0] exc_addr;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [256];

  mem_stage #(.BIT_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_base(in_base),
    .in_offset(in_offset), .in_wdata(in_wdata), .in_dest(in_dest),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_isSigned(ram_isSigned), .ram_dataSize(ram_dataSize), .ram_q(ram_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_dest(out_dest),
    .exc_valid(exc_valid), .exc_addr(exc_addr)
  );

  always #5 clk = ~clk;

  // RAM read: little-endian, extended according to size and signedness.
  always @* begin
    logic [7:0]  b;
    logic [15:0] h;
    b = mem[ram_addr];
    h = {mem[8'(ram_addr + 8'd1)], mem[ram_addr]};
    case (ram_dataSize)
      2'b00:   ram_q = ram_isSigned ? {{24{b[7]}}, b} : {24'd0, b};
      2'b01:   ram_q = ram_isSigned ? {{16{h[15]}}, h} : {16'd0, h};
      default: ram_q = {mem[8'(ram_addr + 8'd3)], mem[8'(ram_addr + 8'd2)], h};
    endcase
  end

  // RAM write: picks the lane that the address selects.
  always @(posedge clk) begin
    if (ram_wren) begin
      case (ram_dataSize)
        2'b00: mem[ram_addr] = ram_data[8*ram_addr[1:0] +: 8];
        2'b01: begin
          mem[ram_addr]                = ram_data[16*ram_addr[1] +: 8];
          mem[8'(ram_addr + 8'd1)]     = ram_data[16*ram_addr[1] + 8 +: 8];
        end
        default: begin
          mem[ram_addr]            = ram_data[7:0];
          mem[8'(ram_addr + 8'd1)] = ram_data[15:8];
          mem[8'(ram_addr + 8'd2)] = ram_data[23:16];
          mem[8'(ram_addr + 8'd3)] = ram_data[31:24];
        end
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] base, input logic [15:0] off,
                       input logic [31:0] wdata, input logic [4:0] dest);
    in_valid  = 1'b1;
    in_op     = op;
    in_base   = base;
    in_offset = off;
    in_wdata  = wdata;
    in_dest   = dest;
  endtask

  // Full load transaction with an immediately ready consumer.
  task automatic do_load(input string tag, input logic [3:0] op, input logic [31:0] base,
                         input logic [15:0] off, input logic [4:0] dest,
                         input logic [7:0] exp_addr, input logic [31:0] exp_data);
    @(negedge clk);
    drive(op, base, off, 32'd0, dest);
    #1;
    chk({tag, "_addr_idle"}, 32'(ram_addr), 32'(exp_addr));
    chk({tag, "_signed"}, 32'(ram_isSigned), 32'(!op[2]));
    chk({tag, "_wren"}, 32'(ram_wren), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk({tag, "_read_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_read_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_addr_read"}, 32'(ram_addr), 32'(exp_addr));
    @(negedge clk);
    #1;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, out_data, exp_data);
    chk({tag, "_dest"}, 32'(out_dest), 32'(dest));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk({tag, "_done_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_done_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic seen_valid;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h1F] = 8'h80;
    mem[8'h40] = 8'h34;
    mem[8'h41] = 8'h12;
    rst_n     = 1'b0;
    out_ready = 1'b0;
    drive(4'b1010, 32'h0000_0030, 16'h0000, 32'hFFFF_FFFF, 5'd1);

    // Reset state, with a store presented that must not reach the RAM
    repeat (2) @(negedge clk);
    #1;
    chk("rst_wren", 32'(ram_wren), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_exc_valid", 32'(exc_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_dest", 32'(out_dest), 32'd0);
    chk("rst_exc_addr", exc_addr, 32'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    // SB
    @(negedge clk);
    drive(4'b1000, 32'h10, 16'd3, 32'h0000_00A5, 5'd0);
    #1;
    chk("sb_wren", 32'(ram_wren), 32'd1);
    chk("sb_addr", 32'(ram_addr), 32'h13);
    chk("sb_data", ram_data, 32'hA5A5_A5A5);
    chk("sb_size", 32'(ram_dataSize), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("sb_wren_off", 32'(ram_wren), 32'd0);
    chk("sb_no_out", 32'(out_valid), 32'd0);
    chk("sb_ready", 32'(in_ready), 32'd1);
    chk("sb_mem", 32'(mem[8'h13]), 32'hA5);
    chk("rst_store_blocked", 32'(mem[8'h30]), 32'h00);

    // LB / LBU across a negative offset
    do_load("lb", 4'b0000, 32'h20, 16'hFFFF, 5'd7, 8'h1F, 32'hFFFF_FF80);
    do_load("lbu", 4'b0100, 32'h20, 16'hFFFF, 5'd8, 8'h1F, 32'h0000_0080);

    // SW then SH replication
    @(negedge clk);
    drive(4'b1010, 32'h30, 16'd0, 32'h1234_5678, 5'd0);
    #1;
    chk("sw_data", ram_data, 32'h1234_5678);
    @(negedge clk);
    drive(4'b1001, 32'h60, 16'd2, 32'h0000_BEEF, 5'd0);
    #1;
    chk("sh_data", ram_data, 32'hBEEF_BEEF);
    chk("sh_addr", 32'(ram_addr), 32'h62);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("sh_mem", {16'd0, mem[8'h63], mem[8'h62]}, 32'h0000_BEEF);

    // LW held by backpressure while a store is offered
    @(negedge clk);
    drive(4'b0010, 32'h2C, 16'd4, 32'd0, 5'd9);
    @(negedge clk);
    drive(4'b1010, 32'h50, 16'd0, 32'hDEAD_BEEF, 5'd0);
    #1;
    chk("lw_read_wren", 32'(ram_wren), 32'd0);
    chk("lw_read_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("lw_hold_valid", 32'(out_valid), 32'd1);
      chk("lw_hold_data", out_data, 32'h1234_5678);
      chk("lw_hold_dest", 32'(out_dest), 32'd9);
      chk("lw_hold_ready", 32'(in_ready), 32'd0);
      chk("lw_hold_wren", 32'(ram_wren), 32'd0);
      if (k == 3) out_ready = 1'b1;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("lw_done_valid", 32'(out_valid), 32'd0);
    chk("lw_done_ready", 32'(in_ready), 32'd1);
    chk("lw_no_store", 32'(mem[8'h50]), 32'h00);

    // LH at an odd address
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    @(negedge clk);
    drive(4'b0001, 32'h41, 16'd0, 32'd0, 5'd3);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("lh_mis_exc", 32'(exc_valid), 32'd1);
    chk("lh_mis_addr", exc_addr, 32'h41);
    chk("lh_mis_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    #1;
    chk("lh_mis_pulse", 32'(exc_valid), 32'd0);
    chk("lh_mis_no_out", 32'(out_valid), 32'd0);
`else
    do_load("lh_mis", 4'b0001, 32'h41, 16'd0, 5'd3, 8'h40, 32'h0000_1234);
`endif

    // Illegal size, with an address that wraps past 2^32
    @(negedge clk);
    drive(4'b0011, 32'hFFFF_FFFF, 16'd2, 32'd0, 5'd4);
    #1;
    chk("ill_ld_wren", 32'(ram_wren), 32'd0);
    @(negedge clk);
    drive(4'b1011, 32'h70, 16'd0, 32'h0000_0011, 5'd0);
    #1;
    chk("ill_st_wren", 32'(ram_wren), 32'd0);
    chk("ill_ld_exc", 32'(exc_valid), 32'd1);
    chk("ill_ld_addr", exc_addr, 32'h0000_0001);
    chk("ill_ld_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("ill_st_exc", 32'(exc_valid), 32'd1);
    chk("ill_st_addr", exc_addr, 32'h70);
    seen_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      if (out_valid) seen_valid = 1'b1;
    end
    chk("ill_exc_end", 32'(exc_valid), 32'd0);
    chk("ill_no_out", 32'(seen_valid), 32'd0);
    chk("ill_no_store", 32'(mem[8'h70]), 32'h00);

    // Reset while a load is in READ
    @(negedge clk);
    drive(4'b0010, 32'h30, 16'd0, 32'd0, 5'd5);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("rr_in_read", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rr_valid", 32'(out_valid), 32'd0);
    chk("rr_ready", 32'(in_ready), 32'd1);
    chk("rr_data", out_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      if (out_valid) seen_valid = 1'b1;
    end
    chk("rr_no_out", 32'(seen_valid), 32'd0);
    chk("rr_ready_after", 32'(in_ready), 32'd1);
    chk("rr_dest", 32'(out_dest), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter BIT_WIDTH, default 32, data path width.
REQ-002 Parameter ADDR_WIDTH, default 8, byte address width driven to the data RAM.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 in_valid / in_ready  in / out  1 / 1  request handshake; transfer when both are high at a clk edge.
REQ-006 in_op  in  4  op[3]=store, op[2]=unsigned, op[1:0]=size (00 byte, 01 half, 10 word, 11 illegal).
REQ-007 in_base  in  32  base register value; in_offset  in  16  signed immediate.
REQ-008 in_wdata  in  32  store data, right-aligned; in_dest  in  5  load destination register.
REQ-009 ram_addr ADDR_WIDTH, ram_data 32, ram_wren 1, ram_isSigned 1, ram_dataSize 2  out  data RAM controls.
REQ-010 ram_q  in  32  data RAM read result, already extended by the RAM.
REQ-011 out_valid / out_ready  out / in  1 / 1  load result handshake.
REQ-012 out_data  out  32  load result; out_dest  out  5  destination register.
REQ-013 exc_valid  out  1  one-cycle exception pulse; exc_addr  out  32  faulting effective address.

Function
REQ-014 Effective address SHALL be in_base + sign-extended in_offset, 32-bit, wrapping modulo 2^32; ram_addr SHALL be its low ADDR_WIDTH bits.
REQ-015 FSM SHALL have states IDLE, READ, RESP; in_ready SHALL be high only in IDLE.
REQ-016 In IDLE the ram_* outputs SHALL be driven combinationally from in_*; in READ they SHALL be driven from the request latched at acceptance.
REQ-017 ram_dataSize SHALL equal op[1:0], and ram_isSigned SHALL equal !op[2].
REQ-018 Accepted store: ram_wren SHALL be high for that cycle only, the FSM SHALL stay in IDLE, and no out_valid SHALL be produced.
REQ-019 Store data SHALL be lane-replicated: byte -> {4{wdata[7:0]}}, half -> {2{wdata[15:0]}}, word unchanged.
REQ-020 Accepted load: IDLE->READ; ram_addr held stable through READ; at the next edge ram_q SHALL be captured into out_data, in_dest into out_dest, and the FSM SHALL go READ->RESP.
REQ-021 RESP: out_valid=1 and out_data/out_dest stable until out_ready=1, then RESP->IDLE; load latency is acceptance edge + 1 edge to out_valid.
REQ-022 ram_wren SHALL never be high outside an accepted store.
REQ-023 An illegal size (op[1:0]=11) SHALL NOT access RAM and SHALL pulse exc_valid the cycle after acceptance with exc_addr=effective address; the FSM SHALL remain in IDLE.
REQ-024 If in_valid and an exception are presented in the same cycle as out_ready in RESP, there is no conflict: requests are only accepted in IDLE.

Reset
REQ-025 While rst_n=0: FSM=IDLE; out_valid, exc_valid = 0; out_data, out_dest, exc_addr = 0; latched request = 0.
REQ-026 Reset asserted during READ or RESP SHALL discard the pending load without output; ram_wren SHALL be 0 during reset.

Configuration
REQ-027 Macro MEM_STAGE_ALIGN_CHECK_EN defined: a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL be treated as in REQ-023 (no RAM access, exc_valid pulse, exc_addr).
REQ-028 Macro undefined: misaligned low address bits SHALL be cleared (half: bit0; word: bits1:0) and the access SHALL proceed normally; exc_valid is then driven only by illegal size.

Structure
REQ-029 Package mem_pkg SHALL hold the op field positions, size codes (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state enum, and the store-replication function.
REQ-030 No sub-module; mem_stage instantiates nothing and connects to dataRAM_r0 at top level.

Verification
REQ-031 SB base=0x10, off=+3, wdata=0x000000A5 -> one-cycle ram_wren, ram_addr=0x13, ram_data=0xA5A5A5A5, ram_dataSize=00.
REQ-032 LB after a RAM byte of 0x80, base=0x20, off=-1 -> ram_addr=0x1F, out_valid one edge after acceptance, out_data=0xFFFFFF80; LBU gives 0x00000080.
REQ-033 LW with out_ready held 0 for 3 cycles -> out_valid/out_data stable for 4 cycles, in_ready=0 throughout, then IDLE.
REQ-034 LH at addr 0x41: with MEM_STAGE_ALIGN_CHECK_EN -> exc_valid one pulse, exc_addr=0x00000041, no RAM access; without it -> access at 0x40.
REQ-035 op=4'b0011 -> exc_valid pulse, ram_wren=0, out_valid never rises.
REQ-036 rst_n low in READ -> out_valid=0, FSM IDLE, in_ready=1 after release, no spurious output.
